mwadd_seq: RTL and testbench

Multi-byte sequential adder that sits directly upstream of the 8-bit carry-lookahead adder `cla_8` and drives it. It accepts two NBYTES-wide operands over a valid/ready handshake, feeds them to its single internal `cla_8` instance one byte pair per cycle (LSB first), and chains the carry through a register. It returns the full-width sum, carry-out and signed-overflow flag over a second valid/ready handshake. This gives wide additions without widening the combinational adder.

---
 rtl/mwadd_seq.sv | 159 +++++++++++++++
 tb/tb_mwadd_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mwadd_seq.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Module   : mwadd_seq (with cla_8)
// Brief    : Multi-byte sequential adder, one byte per cycle through a cla_8.
// Revision : 1.0 - initial release
// =============================================================================

module cla_8 (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] s,
   output logic       cout
);
   logic [7:0] w_g;
   logic [7:0] w_p;
   logic [8:0] w_c;
   logic       w_pp;

   assign w_g = a & b;
   assign w_p = a ^ b;

   // Each carry is the flat sum-of-products of generate/propagate terms.
   always_comb begin
      w_c    = '0;
      w_pp   = 1'b0;
      w_c[0] = cin;
      for (int i = 0; i < 8; i++) begin
         w_c[i+1] = w_g[i];
         w_pp     = w_p[i];
         for (int j = i - 1; j >= 0; j--) begin
            w_c[i+1] = w_c[i+1] | (w_pp & w_g[j]);
            w_pp     = w_pp & w_p[j];
         end
         w_c[i+1] = w_c[i+1] | (w_pp & cin);
      end
   end

   assign s    = w_p ^ w_c[7:0];
   assign cout = w_c[8];
endmodule

module mwadd_seq #(
   parameter int NBYTES = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [8*NBYTES-1:0]   a_in,
   input  logic [8*NBYTES-1:0]   b_in,
   input  logic                  cin,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [8*NBYTES-1:0]   sum,
   output logic                  cout,
   output logic                  ovf,
   output logic                  busy
);
   localparam int c_IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [c_IDXW-1:0] c_LAST = c_IDXW'(NBYTES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADD  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                     r_state;
   state_t                     w_state_nxt;
   logic [NBYTES-1:0][7:0]     r_a;
   logic [NBYTES-1:0][7:0]     r_b;
   logic [NBYTES-1:0][7:0]     r_sum;
   logic [c_IDXW-1:0]          r_idx;
   logic                       r_carry;
   logic                       r_cout;
   logic                       r_ovf;
   logic                       w_accept;
   logic                       w_last;
   logic [7:0]                 w_abyte;
   logic [7:0]                 w_bbyte;
   logic [7:0]                 w_s;
   logic                       w_co;

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      busy        = 1'b0;
      w_accept    = 1'b0;
      w_last      = (r_idx == c_LAST);
      case (r_state)
         S_IDLE: begin
            in_ready = rst_n;
            w_accept = in_valid & rst_n;
            if (w_accept) w_state_nxt = S_ADD;
         end
         S_ADD: begin
            busy = 1'b1;
            if (w_last) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_abyte = r_a[r_idx];
   assign w_bbyte = r_b[r_idx];

   cla_8 u_cla (
      .a    (w_abyte),
      .b    (w_bbyte),
      .cin  (r_carry),
      .s    (w_s),
      .cout (w_co)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_idx   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (w_accept) begin
         r_a     <= a_in;
         r_b     <= b_in;
         r_carry <= cin;
         r_idx   <= '0;
      end else if (r_state == S_ADD) begin
         r_sum[r_idx] <= w_s;
         r_carry      <= w_co;
         if (w_last) begin
            // Carry into the MSB is recovered from the final byte's sign bits.
            r_cout <= w_co;
            r_ovf  <= w_abyte[7] ^ w_bbyte[7] ^ w_s[7] ^ w_co;
         end else begin
            r_idx <= r_idx + 1'b1;
         end
      end
   end

   assign sum  = r_sum;
   assign cout = r_cout;
   assign ovf  = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_mwadd_seq.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Module   : tb_mwadd_seq
// Brief    : Scoreboard bench for mwadd_seq at NBYTES=4 and NBYTES=1.
// Revision : 1.0 - initial release
// =============================================================================
module tb_mwadd_seq;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst4_n, iv4, ir4, ci4, ov4, or4, co4, of4, bsy4;
   logic [31:0] a4, b4, s4;
   logic        rst1_n, iv1, ir1, ci1, ov1, or1, co1, of1, bsy1;
   logic [7:0]  a1, b1, s1;
   logic        b2b4 = 1'b0;
   logic        b2b1 = 1'b0;
   logic        done1 = 1'b0;

   mwadd_seq #(.NBYTES(4)) u_dut4 (
      .clk(clk), .rst_n(rst4_n), .in_valid(iv4), .in_ready(ir4),
      .a_in(a4), .b_in(b4), .cin(ci4), .out_valid(ov4), .out_ready(or4),
      .sum(s4), .cout(co4), .ovf(of4), .busy(bsy4)
   );

   mwadd_seq #(.NBYTES(1)) u_dut1 (
      .clk(clk), .rst_n(rst1_n), .in_valid(iv1), .in_ready(ir1),
      .a_in(a1), .b_in(b1), .cin(ci1), .out_valid(ov1), .out_ready(or1),
      .sum(s1), .cout(co1), .ovf(of1), .busy(bsy1)
   );

   typedef struct {
      logic [31:0] s;
      logic        c;
      logic        o;
      int          acc;
   } exp_t;

   exp_t        q [2][$];
   int          checks = 0;
   int          errors = 0;
   int          ncyc = 0;
   int          last_acc [2] = '{-1, -1};
   logic        p_rn [2] = '{1'b1, 1'b1};
   logic        p_ov [2] = '{1'b0, 1'b0};
   logic        p_or [2] = '{1'b0, 1'b0};
   logic        p_co [2] = '{1'b0, 1'b0};
   logic        p_of [2] = '{1'b0, 1'b0};
   logic [31:0] p_s  [2] = '{32'd0, 32'd0};

   // Reference: plain integer arithmetic on unsigned and signed views.
   function automatic exp_t model(input int nb, input logic [31:0] a, input logic [31:0] b,
                                  input logic ci, input int acc);
      exp_t e;
      longint m    = (longint'(1) << (8 * nb)) - 1;
      longint half = longint'(1) << (8 * nb - 1);
      longint ua   = longint'(a) & m;
      longint ub   = longint'(b) & m;
      longint full = ua + ub + longint'(ci);
      longint sa   = (ua >= half) ? ua - (m + 1) : ua;
      longint sb   = (ub >= half) ? ub - (m + 1) : ub;
      longint sr   = sa + sb + longint'(ci);
      e.s   = 32'(full & m);
      e.c   = ((full >> (8 * nb)) & 1) != 0;
      e.o   = (sr > half - 1) || (sr < -half);
      e.acc = acc;
      return e;
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, ncyc);
      end
   endtask

   task automatic mon(input int d, input int nb, input logic rn, input logic iv, input logic ir,
                      input logic [31:0] a, input logic [31:0] b, input logic ci,
                      input logic ov, input logic ordy, input logic [31:0] s,
                      input logic co, input logic of, input logic bsy, input logic bb);
      exp_t e;
      chk($sformatf("in_ready_nb%0d", nb), 64'(ir), 64'(rn & ~bsy));
      if (!p_rn[d])
         chk($sformatf("reset_state_nb%0d", nb), 64'({ov, bsy, co, of, s}), 64'd0);
      if (!rn) begin
         q[d].delete();
         last_acc[d] = -1;
      end else begin
         if (p_rn[d] && p_ov[d] && !p_or[d])
            chk($sformatf("hold_nb%0d", nb), 64'({ov, co, of, s}), 64'({1'b1, p_co[d], p_of[d], p_s[d]}));
         if (p_rn[d] && p_ov[d] && p_or[d])
            chk($sformatf("idle_after_hs_nb%0d", nb), 64'({ov, ir}), 64'd1);
         if (ov && !p_ov[d] && q[d].size() > 0)
            chk($sformatf("latency_nb%0d", nb), 64'(ncyc - q[d][0].acc), 64'(nb + 1));
         if (ov && ordy) begin
            if (q[d].size() == 0) begin
               chk($sformatf("unexpected_result_nb%0d", nb), 64'd1, 64'd0);
            end else begin
               e = q[d].pop_front();
               chk($sformatf("result_nb%0d", nb), 64'({s, co, of}), 64'({e.s, e.c, e.o}));
            end
         end else if (q[d].size() > 0 && ncyc - q[d][0].acc > nb + 60) begin
            chk($sformatf("result_timeout_nb%0d", nb), 64'd1, 64'd0);
            void'(q[d].pop_front());
         end
         if (iv && ir) begin
            if (bb && last_acc[d] >= 0)
               chk($sformatf("accept_spacing_nb%0d", nb), 64'(ncyc - last_acc[d]), 64'(nb + 2));
            q[d].push_back(model(nb, a, b, ci, ncyc));
            last_acc[d] = bb ? ncyc : -1;
         end
      end
      p_rn[d] = rn;
      p_ov[d] = ov;
      p_or[d] = ordy;
      p_co[d] = co;
      p_of[d] = of;
      p_s[d]  = s;
   endtask

   // Monitor: sampled mid-cycle, describes what the next rising edge will do.
   always @(negedge clk) begin
      ncyc++;
      mon(0, 4, rst4_n, iv4, ir4, a4, b4, ci4, ov4, or4, s4, co4, of4, bsy4, b2b4);
      mon(1, 1, rst1_n, iv1, ir1, {24'd0, a1}, {24'd0, b1}, ci1, ov1, or1,
          {24'd0, s1}, co1, of1, bsy1, b2b1);
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic send4(input logic [31:0] a, input logic [31:0] b, input logic ci);
      a4 = a; b4 = b; ci4 = ci; iv4 = 1'b1;
      for (int k = 0; k < 40; k++) begin
         if (ir4) break;
         cyc();
      end
      if (!ir4) begin
         $display("FAIL send4_accept: in_ready=%0b required 1", ir4);
         $fatal(1, "bench stopped");
      end
      cyc();
      iv4 = 1'b0;
   endtask

   task automatic wait_res4();
      for (int k = 0; k < 60; k++) begin
         if (ov4 && or4) begin
            cyc();
            return;
         end
         cyc();
      end
      $display("FAIL wait_result4: out_valid=%0b required 1", ov4);
      $fatal(1, "bench stopped");
   endtask

   initial begin
      rst1_n = 1'b0; iv1 = 1'b0; or1 = 1'b1; a1 = '0; b1 = '0; ci1 = 1'b0;
      repeat (3) cyc();
      rst1_n = 1'b1;
      cyc();
      b2b1 = 1'b1; iv1 = 1'b1;
      for (int i = 0; i < 300; i++) begin
         a1 = 8'($urandom); b1 = 8'($urandom); ci1 = 1'($urandom);
         cyc();
      end
      iv1 = 1'b0; b2b1 = 1'b0;
      repeat (5) cyc();
      done1 = 1'b1;
   end

   initial begin
      rst4_n = 1'b0; iv4 = 1'b0; or4 = 1'b1; a4 = '0; b4 = '0; ci4 = 1'b0;
      repeat (3) cyc();
      rst4_n = 1'b1;
      cyc();
      send4(32'hFFFF_FFFF, 32'h0000_0001, 1'b0); wait_res4();
      send4(32'h7FFF_FFFF, 32'h0000_0000, 1'b1); wait_res4();
      send4(32'h1234_5678, 32'h9ABC_DEF0, 1'b0); wait_res4();

      // Backpressure with a pending request held on the input side.
      or4 = 1'b0;
      send4($urandom, $urandom, 1'($urandom));
      for (int k = 0; k < 40; k++) begin
         if (ov4) break;
         cyc();
      end
      iv4 = 1'b1;
      for (int k = 0; k < 5; k++) begin
         a4 = $urandom; b4 = $urandom;
         cyc();
      end
      or4 = 1'b1;
      cyc();
      send4(a4, b4, ci4); wait_res4();

      // Reset sampled on the second ADD edge.
      send4($urandom, $urandom, 1'b1);
      cyc();
      rst4_n = 1'b0;
      cyc();
      rst4_n = 1'b1;
      repeat (2) cyc();
      send4(32'd1, 32'd1, 1'b0); wait_res4();

      b2b4 = 1'b1; iv4 = 1'b1;
      for (int i = 0; i < 600; i++) begin
         a4 = $urandom; b4 = $urandom; ci4 = 1'($urandom);
         cyc();
      end
      iv4 = 1'b0; b2b4 = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         if (done1) break;
         cyc();
      end
      repeat (10) cyc();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
